// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stall vector layout, stage indices and the per-stage latch action.
package pipe_pkg;

  localparam int unsigned STALL_W = 6;

  localparam int unsigned STG_IF   = 0;
  localparam int unsigned STG_ID   = 1;
  localparam int unsigned STG_EX   = 2;
  localparam int unsigned STG_MEM  = 3;
  localparam int unsigned STG_WB   = 4;
  localparam int unsigned STG_CTRL = 5;

  typedef enum logic [1:0] {
    FLUSH,
    LOAD,
    BUBBLE,
    HOLD
  } stage_act_e;

  // Priority: flush, then upstream free, then downstream free, otherwise hold.
  function automatic stage_act_e decode_act(logic flush, logic up_stall, logic dn_stall);
    if (flush) begin
      return FLUSH;
    end else if (!up_stall) begin
      return LOAD;
    end else if (!dn_stall) begin
      return BUBBLE;
    end else begin
      return HOLD;
    end
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment) and async reset.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != {W{1'b1}})) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic latch between pipeline stage STAGE and STAGE+1 with valid bit, multi-cycle scratch
// loop-back and saturating bubble/hold statistics.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = 200,
  parameter int unsigned AUX_W     = 66,
  parameter int unsigned STAGE     = 3,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned MC_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [STALL_W-1:0]   stall,
  input  logic                 flush,
  input  logic                 perf_clr,
  input  logic                 in_valid,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [AUX_W-1:0]     aux_i,
  output logic                 out_valid,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [AUX_W-1:0]     aux_o,
  output logic [MC_W-1:0]      mc_cycles,
  output logic [CNT_W-1:0]     cnt_bubble,
  output logic [CNT_W-1:0]     cnt_hold
);

  if (STAGE > STALL_W - 2) begin : g_stage_check
    $error("pipe_stage_reg: STAGE must not exceed STALL_W-2");
  end

  stage_act_e act;

  logic                 valid_q, valid_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic [AUX_W-1:0]     aux_q, aux_d;

  // Only the upstream and downstream bits matter; the rest are deliberately ignored.
  logic unused_stall;
  assign unused_stall = ^stall;

  always_comb begin
    act = decode_act(flush, stall[STAGE], stall[STAGE+1]);
  end

  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    aux_d     = '0;
    unique case (act)
      FLUSH: begin
        valid_d   = 1'b0;
        payload_d = '0;
      end
      LOAD: begin
        valid_d   = in_valid;
        payload_d = in_payload;
      end
      BUBBLE: begin
        valid_d   = 1'b0;
        payload_d = '0;
        aux_d     = aux_i;
      end
      HOLD: begin
        // Payload and valid are held; scratch is only live right after a bubble.
      end
      default: begin
        valid_d   = 1'b0;
        payload_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
      aux_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
      aux_q     <= aux_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_payload = payload_q;
  assign aux_o       = aux_q;

  logic act_bubble, act_hold, mc_clr;
  assign act_bubble = (act == BUBBLE);
  assign act_hold   = (act == HOLD);
  assign mc_clr     = (act == FLUSH) || (act == LOAD);

  sat_counter #(
    .W(MC_W)
  ) u_mc_cycles (
    .clk(clk),
    .rst(rst),
    .clr(mc_clr),
    .inc(act_bubble),
    .q  (mc_cycles)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_cnt_bubble (
    .clk(clk),
    .rst(rst),
    .clr(perf_clr),
    .inc(act_bubble),
    .q  (cnt_bubble)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_cnt_hold (
    .clk(clk),
    .rst(rst),
    .clr(perf_clr),
    .inc(act_hold),
    .q  (cnt_hold)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: three differently parametrised stage registers share one stimulus stream.
module tb_pipe_stage_reg;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stall;
  logic         flush;
  logic         perf_clr;
  logic         in_valid;
  logic [199:0] in_payload;
  logic [65:0]  aux_i;

  always #5 clk = ~clk;

  // A: defaults. B: 4-bit perf counters. C: STAGE 0, narrow payload/aux.
  logic         v_a, v_b, v_c;
  logic [199:0] p_a, p_b;
  logic [63:0]  p_c;
  logic [65:0]  x_a, x_b;
  logic [0:0]   x_c;
  logic [3:0]   mc_a, mc_b, mc_c;
  logic [31:0]  cb_a, ch_a, cb_c, ch_c;
  logic [3:0]   cb_b, ch_b;

  pipe_stage_reg u_dut_a (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .perf_clr(perf_clr),
    .in_valid(in_valid), .in_payload(in_payload), .aux_i(aux_i),
    .out_valid(v_a), .out_payload(p_a), .aux_o(x_a), .mc_cycles(mc_a),
    .cnt_bubble(cb_a), .cnt_hold(ch_a)
  );

  pipe_stage_reg #(.CNT_W(4), .MC_W(4)) u_dut_b (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .perf_clr(perf_clr),
    .in_valid(in_valid), .in_payload(in_payload), .aux_i(aux_i),
    .out_valid(v_b), .out_payload(p_b), .aux_o(x_b), .mc_cycles(mc_b),
    .cnt_bubble(cb_b), .cnt_hold(ch_b)
  );

  pipe_stage_reg #(.STAGE(0), .PAYLOAD_W(64), .AUX_W(1)) u_dut_c (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .perf_clr(perf_clr),
    .in_valid(in_valid), .in_payload(in_payload[63:0]), .aux_i(aux_i[0:0]),
    .out_valid(v_c), .out_payload(p_c), .aux_o(x_c), .mc_cycles(mc_c),
    .cnt_bubble(cb_c), .cnt_hold(ch_c)
  );

  typedef struct {
    logic         v;
    logic [199:0] p;
    logic [65:0]  x;
    logic [31:0]  mc;
    logic [31:0]  cb;
    logic [31:0]  ch;
  } st_t;

  st_t ma, mb, mc;
  st_t q_a[$], q_b[$], q_c[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic st_t zero_st();
    st_t s;
    s.v = 1'b0; s.p = '0; s.x = '0; s.mc = '0; s.cb = '0; s.ch = '0;
    return s;
  endfunction

  // Reference behaviour of one stage register for the inputs currently driven.
  function automatic st_t model_next(st_t s, int stage, int pw, int aw, int cw, int mw);
    st_t          n = s;
    logic [199:0] pmask = {200{1'b1}} >> (200 - pw);
    logic [65:0]  amask = {66{1'b1}} >> (66 - aw);
    logic [31:0]  cmax  = 32'hFFFF_FFFF >> (32 - cw);
    logic [31:0]  mmax  = 32'hFFFF_FFFF >> (32 - mw);
    n.x = '0;
    if (flush) begin
      n.v = 1'b0; n.p = '0; n.mc = '0;
    end else if (!stall[stage]) begin
      n.v = in_valid; n.p = in_payload & pmask; n.mc = '0;
    end else if (!stall[stage+1]) begin
      n.v = 1'b0; n.p = '0; n.x = aux_i & amask;
      if (s.mc < mmax) n.mc = s.mc + 1;
      if (s.cb < cmax) n.cb = s.cb + 1;
    end else begin
      if (s.ch < cmax) n.ch = s.ch + 1;
    end
    if (perf_clr) begin
      n.cb = '0; n.ch = '0;
    end
    return n;
  endfunction

  task automatic step();
    st_t ea, eb, ec;
    ma = model_next(ma, 3, 200, 66, 32, 4); q_a.push_back(ma);
    mb = model_next(mb, 3, 200, 66, 4, 4);  q_b.push_back(mb);
    mc = model_next(mc, 0, 64, 1, 32, 4);   q_c.push_back(mc);
    @(posedge clk);
    #1;
    ea = q_a.pop_front();
    eb = q_b.pop_front();
    ec = q_c.pop_front();
    chk("A.valid", 256'(v_a), 256'(ea.v));   chk("A.payload", 256'(p_a), 256'(ea.p));
    chk("A.aux", 256'(x_a), 256'(ea.x));     chk("A.mc", 256'(mc_a), 256'(ea.mc));
    chk("A.bubble", 256'(cb_a), 256'(ea.cb)); chk("A.hold", 256'(ch_a), 256'(ea.ch));
    chk("B.valid", 256'(v_b), 256'(eb.v));   chk("B.payload", 256'(p_b), 256'(eb.p));
    chk("B.aux", 256'(x_b), 256'(eb.x));     chk("B.mc", 256'(mc_b), 256'(eb.mc));
    chk("B.bubble", 256'(cb_b), 256'(eb.cb)); chk("B.hold", 256'(ch_b), 256'(eb.ch));
    chk("C.valid", 256'(v_c), 256'(ec.v));   chk("C.payload", 256'(p_c), 256'(ec.p));
    chk("C.aux", 256'(x_c), 256'(ec.x));     chk("C.mc", 256'(mc_c), 256'(ec.mc));
    chk("C.bubble", 256'(cb_c), 256'(ec.cb)); chk("C.hold", 256'(ch_c), 256'(ec.ch));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".A"}, {v_a, p_a, x_a, mc_a, cb_a, ch_a}, '0);
    chk({tag, ".B"}, {v_b, p_b, x_b, mc_b, cb_b, ch_b}, '0);
    chk({tag, ".C"}, {v_c, p_c, x_c, mc_c, cb_c, ch_c}, '0);
  endtask

  task automatic drive(input logic [5:0] s, input logic f, input logic pc, input logic iv,
                       input logic [199:0] p, input logic [65:0] x);
    stall = s; flush = f; perf_clr = pc; in_valid = iv; in_payload = p; aux_i = x;
  endtask

  logic [199:0] pat_a5;
  logic [199:0] pat_p;
  logic [65:0]  aux_val;
  logic [223:0] rnd;

  initial begin
    pat_a5  = {8'hA5, {23{8'h3C}}, 8'h5A};
    pat_p   = {40{5'b10110}};
    aux_val = 66'h2_DEADBEEF_00000001;
    ma = zero_st(); mb = zero_st(); mc = zero_st();
    rst = 1'b1;
    drive(6'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // Load, then a short bubble run so there is live state to destroy.
    drive(6'b000000, 1'b0, 1'b0, 1'b1, pat_a5, '0);
    step();
    chk("A.load_const", 256'(p_a), 256'(pat_a5));
    drive(6'b001000, 1'b0, 1'b0, 1'b0, pat_p, aux_val);
    step();
    step();

    // Asynchronous reset mid-cycle, checked before any further edge.
    #1 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    ma = zero_st(); mb = zero_st(); mc = zero_st();
    #1 rst = 1'b0;

    drive(6'b000000, 1'b0, 1'b0, 1'b1, pat_a5, '0);
    step();
    chk("A.valid_const", 256'(v_a), 256'(1'b1));

    drive(6'b001000, 1'b0, 1'b0, 1'b1, pat_p, aux_val);
    repeat (3) step();
    chk("A.mc3", 256'(mc_a), 256'(4'd3));
    chk("A.bubble3", 256'(cb_a), 256'(32'd3));
    chk("A.aux_track", 256'(x_a), 256'(aux_val));

    drive(6'b000000, 1'b0, 1'b0, 1'b1, pat_p, aux_val);
    step();
    drive(6'b011000, 1'b0, 1'b0, 1'b0, pat_a5, aux_val);
    repeat (4) step();
    chk("A.hold4", 256'(ch_a), 256'(32'd4));
    chk("A.hold_payload", 256'(p_a), 256'(pat_p));

    drive(6'b011000, 1'b1, 1'b0, 1'b1, pat_a5, aux_val);
    step();
    chk("A.flush_hold_cnt", 256'(ch_a), 256'(32'd4));
    chk("A.flush_valid", 256'(v_a), 256'(1'b0));

    // Clear coinciding with a bubble: clear wins.
    drive(6'b001000, 1'b0, 1'b0, 1'b0, '0, aux_val);
    step();
    drive(6'b001000, 1'b0, 1'b1, 1'b0, '0, aux_val);
    step();
    chk("A.clr_wins", 256'(cb_a), 256'(32'd0));

    drive(6'b001000, 1'b0, 1'b0, 1'b0, '0, aux_val);
    repeat (20) step();
    chk("B.bubble_sat", 256'(cb_b), 256'(4'd15));
    chk("B.mc_sat", 256'(mc_b), 256'(4'd15));

    // STAGE 0 instance: only stall[1:0] matter.
    drive(6'b111100, 1'b0, 1'b0, 1'b1, pat_a5, aux_val);
    step();
    chk("C.upper_ignored", 256'(p_c), 256'(pat_a5[63:0]));
    drive(6'b000001, 1'b0, 1'b0, 1'b1, pat_p, aux_val);
    step();
    drive(6'b000011, 1'b0, 1'b0, 1'b1, pat_p, aux_val);
    step();
    drive(6'b111101, 1'b0, 1'b0, 1'b1, pat_p, aux_val);
    step();

    for (int i = 0; i < 60; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      drive(6'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
            1'($urandom), rnd[199:0], {2'($urandom), $urandom, $urandom});
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
